// File: rtl/nios2os_sysid_checker.sv
// Boot-time sysid verifier: reads sysid_qsys word 0 (ID) and word 1 (timestamp) over
// Avalon-MM, compares them against the expected build, and reports pass/fail/timeout.
module nios2os_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'd2,
   parameter logic [31:0] EXPECTED_TS    = 32'd1548746340,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ID,
      S_RD_TS,
      S_CHECK,
      S_DONE
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          auto_q, auto_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;
   logic          id_ok_q, id_ok_d;
   logic          ts_ok_q, ts_ok_d;
   logic          timeout_q, timeout_d;
   logic          avm_read_q, avm_read_d;
   logic          avm_address_q, avm_address_d;
   logic [31:0]   id_value_q, id_value_d;
   logic [31:0]   ts_value_q, ts_value_d;
   logic          launch;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      auto_d     = auto_q;
      pass_d     = pass_q;
      id_ok_d    = id_ok_q;
      ts_ok_d    = ts_ok_q;
      timeout_d  = timeout_q;
      id_value_d = id_value_q;
      ts_value_d = ts_value_q;
      launch     = 1'b0;

      case (state_q)
         S_IDLE:  launch = start | auto_q;
         S_DONE:  launch = start;
         S_RD_ID, S_RD_TS: begin
            if (!avm_waitrequest) begin
               cnt_d = '0;
               if (state_q == S_RD_ID) begin
                  id_value_d = avm_readdata;
                  state_d    = S_RD_TS;
               end else begin
                  ts_value_d = avm_readdata;
                  state_d    = S_CHECK;
               end
            end else if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               timeout_d = 1'b1;
               pass_d    = 1'b0;
               state_d   = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_CHECK: begin
            id_ok_d = (id_value_q == EXPECTED_ID);
            ts_ok_d = (ts_value_q == EXPECTED_TS);
            pass_d  = (id_value_q == EXPECTED_ID) && (ts_value_q == EXPECTED_TS);
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

      // A single launch consumes both start and the auto-start flag, so coincident requests run once.
      if (launch) begin
         state_d   = S_RD_ID;
         auto_d    = 1'b0;
         cnt_d     = '0;
         pass_d    = 1'b0;
         id_ok_d   = 1'b0;
         ts_ok_d   = 1'b0;
         timeout_d = 1'b0;
      end

      // Status and bus strobes are registered from the next state to keep outputs glitch-free.
      busy_d        = (state_d == S_RD_ID) || (state_d == S_RD_TS) || (state_d == S_CHECK);
      done_d        = (state_d == S_DONE);
      avm_read_d    = (state_d == S_RD_ID) || (state_d == S_RD_TS);
      avm_address_d = (state_d == S_RD_TS);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         auto_q        <= AUTO_START;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         id_ok_q       <= 1'b0;
         ts_ok_q       <= 1'b0;
         timeout_q     <= 1'b0;
         avm_read_q    <= 1'b0;
         avm_address_q <= 1'b0;
         id_value_q    <= '0;
         ts_value_q    <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         auto_q        <= auto_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
         id_ok_q       <= id_ok_d;
         ts_ok_q       <= ts_ok_d;
         timeout_q     <= timeout_d;
         avm_read_q    <= avm_read_d;
         avm_address_q <= avm_address_d;
         id_value_q    <= id_value_d;
         ts_value_q    <= ts_value_d;
      end
   end

   assign avm_read    = avm_read_q;
   assign avm_address = avm_address_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;
   assign timeout     = timeout_q;
   assign id_value    = id_value_q;
   assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_nios2os_sysid_checker.sv
// Self-checking bench for nios2os_sysid_checker: a configurable sysid slave plus an
// outcome model (latency, read counts, flags) derived from the stall/data of each run.
module tb_nios2os_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'd2;
   localparam logic [31:0] EXP_TS = 32'd1548746340;
   localparam int unsigned T      = 12;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        busy, done, pass, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Slave configuration and bus activity history
   logic [31:0] sl_data  [2];
   int unsigned sl_stall [2];
   int unsigned scnt      = 0;
   int unsigned rd_total  = 0;
   int unsigned acc_total = 0;
   logic [7:0]  acc_hist  = '0;

   // Reference state: last words the checker should be holding
   logic [31:0] m_id, m_ts;

   nios2os_sysid_checker #(
      .EXPECTED_ID   (EXP_ID),
      .EXPECTED_TS   (EXP_TS),
      .TIMEOUT_CYCLES(T),
      .AUTO_START    (1'b1)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .start          (start),
      .avm_address    (avm_address),
      .avm_read       (avm_read),
      .avm_waitrequest(avm_waitrequest),
      .avm_readdata   (avm_readdata),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .id_ok          (id_ok),
      .ts_ok          (ts_ok),
      .timeout        (timeout),
      .id_value       (id_value),
      .ts_value       (ts_value)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign avm_waitrequest = avm_read && (scnt < sl_stall[avm_address]);
   assign avm_readdata    = sl_data[avm_address];

   always @(posedge clock) begin
      if (avm_read && avm_waitrequest) scnt <= scnt + 1;
      else                             scnt <= 0;
      if (avm_read) rd_total <= rd_total + 1;
      if (avm_read && !avm_waitrequest) begin
         acc_total <= acc_total + 1;
         acc_hist  <= {acc_hist[6:0], avm_address};
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_flags"}, {24'd0, busy, done, pass, id_ok, ts_ok, timeout, avm_read, avm_address}, 32'd0);
      chk({tag, "_id_value"}, id_value, 32'd0);
      chk({tag, "_ts_value"}, ts_value, 32'd0);
   endtask

   // mode 0: start pulse; mode 1: reset release (auto-start); mode 2: reset release with start high
   task automatic run(input int mode, input int unsigned s0, input int unsigned s1,
                      input logic [31:0] d0, input logic [31:0] d1, input bit noise);
      int unsigned lat, rdc, acc, k, rd0, acc0;
      bit          to, e_id_ok, e_ts_ok;
      sl_data[0]  = d0;
      sl_data[1]  = d1;
      sl_stall[0] = s0;
      sl_stall[1] = s1;
      // A read accepts after s stalled cycles unless s reaches the timeout budget T.
      if (s0 >= T) begin
         to = 1'b1; lat = T + 1; rdc = T; acc = 0;
      end else if (s1 >= T) begin
         to = 1'b1; lat = s0 + T + 2; rdc = s0 + 1 + T; acc = 1; m_id = d0;
      end else begin
         to = 1'b0; lat = s0 + s1 + 4; rdc = s0 + s1 + 2; acc = 2; m_id = d0; m_ts = d1;
      end
      e_id_ok = !to && (d0 == EXP_ID);
      e_ts_ok = !to && (d1 == EXP_TS);

      @(negedge clock);
      rd0  = rd_total;
      acc0 = acc_total;
      if (mode == 0) start = 1'b1;
      else begin
         reset_n = 1'b1;
         start   = (mode == 2);
      end
      k = 0;
      while (k < lat + 20) begin
         @(posedge clock);
         k++;
         #1;
         if (done) break;
         start = (noise && (k + 2 <= lat)) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      start = 1'b0;

      chk("latency", k, lat);
      chk("done", {31'd0, done}, 32'd1);
      chk("busy", {31'd0, busy}, 32'd0);
      chk("timeout", {31'd0, timeout}, {31'd0, to});
      chk("id_ok", {31'd0, id_ok}, {31'd0, e_id_ok});
      chk("ts_ok", {31'd0, ts_ok}, {31'd0, e_ts_ok});
      chk("pass", {31'd0, pass}, {31'd0, e_id_ok && e_ts_ok});
      chk("id_value", id_value, m_id);
      chk("ts_value", ts_value, m_ts);
      chk("accepted_reads", acc_total - acc0, acc);
      chk("read_cycles", rd_total - rd0, rdc);
      if (acc == 2) chk("address_order", {30'd0, acc_hist[1:0]}, 32'd1);

      repeat (3) @(posedge clock);
      #1;
      chk("done_held", {31'd0, done}, 32'd1);
      chk("idle_read", {31'd0, avm_read}, 32'd0);
      chk("no_rerun", acc_total - acc0, acc);
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      m_id    = '0;
      m_ts    = '0;
      sl_data[0] = EXP_ID;  sl_data[1] = EXP_TS;
      sl_stall[0] = 0;      sl_stall[1] = 0;
      repeat (3) @(posedge clock);
      #1;
      chk_reset_outputs("reset");

      run(1, 0, 0, EXP_ID, EXP_TS, 1'b0);            // auto-start after reset, good image
      run(0, 0, 0, 32'd3, EXP_TS, 1'b0);             // wrong ID
      run(0, 0, 10, EXP_ID, EXP_TS, 1'b0);           // long stall on timestamp
      run(0, 1000, 0, EXP_ID, EXP_TS, 1'b0);         // stuck waitrequest on ID
      run(0, 0, 0, EXP_ID, EXP_TS, 1'b0);            // recovery clears timeout
      run(0, 2, 1000, 32'h1234_5678, EXP_TS, 1'b0);  // stuck waitrequest on timestamp
      run(0, T - 1, T - 1, EXP_ID, 32'd7, 1'b0);     // last stall cycle still accepts
      run(0, T, 0, EXP_ID, EXP_TS, 1'b0);            // first stall count that times out
      run(0, 1, 3, EXP_ID, EXP_TS, 1'b1);            // start pulses while busy are ignored

      for (int i = 0; i < 8; i++) begin
         run(0, $urandom_range(0, 4), $urandom_range(0, 4),
             $urandom_range(0, 1) ? EXP_ID : $urandom,
             $urandom_range(0, 1) ? EXP_TS : $urandom,
             1'($urandom_range(0, 1)));
      end

      // Reset while the ID read is stalled, then release with start coincident with auto-start
      sl_stall[0] = 20;
      sl_stall[1] = 0;
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("mid_read_active", {31'd0, avm_read}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      m_id = '0;
      m_ts = '0;
      run(2, 0, 0, EXP_ID, EXP_TS, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
